// File: rtl/result_output_unit.sv
// Result output unit: latches the final result vector, scans for the argmax,
// then streams the vector and class index to the host as a byte stream.
module result_output_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_N      = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture,
  input  logic [OUT_N-1:0][DATA_WIDTH-1:0] y_in,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [IDX_WIDTH-1:0]         class_idx,
  output logic signed [DATA_WIDTH-1:0] class_max,
  output logic                         class_valid
);

  localparam int PTR_W = $clog2(OUT_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STREAM,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] lat [OUT_N];
  logic signed [DATA_WIDTH-1:0] best_val;
  logic signed [DATA_WIDTH-1:0] cand_val;
  logic signed [DATA_WIDTH-1:0] scan_val;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic [IDX_WIDTH-1:0]         cand_idx;
  logic [PTR_W-1:0]             scan_ptr;
  logic [PTR_W-1:0]             out_ptr;
  logic [PTR_W-1:0]             out_nxt;
  logic                         accept;
  logic                         scan_end;
  logic                         xfer;
  logic                         take;

  always_comb begin
    accept   = capture && (state == IDLE || state == HOLD);
    scan_end = (state == SCAN) && (scan_ptr == PTR_W'(OUT_N - 1));
    xfer     = (state == STREAM) && out_valid && out_ready;
    out_nxt  = out_ptr + 1'b1;
    scan_val = lat[scan_ptr];
    // strict compare keeps the lowest index on ties
    take     = scan_val > best_val;
    cand_val = take ? scan_val : best_val;
    cand_idx = take ? IDX_WIDTH'(scan_ptr) : best_idx;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      HOLD:    if (accept) state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = STREAM;
      STREAM:  if (xfer && out_last) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN) || (state == STREAM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OUT_N; k++) begin
        lat[k] <= '0;
      end
      best_val    <= '0;
      best_idx    <= '0;
      scan_ptr    <= '0;
      out_ptr     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      class_idx   <= '0;
      class_max   <= '0;
      class_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < OUT_N; k++) begin
          lat[k] <= y_in[k];
        end
        best_val    <= y_in[0];
        best_idx    <= '0;
        scan_ptr    <= PTR_W'(1);
        class_valid <= 1'b0;
      end

      if (state == SCAN) begin
        best_val <= cand_val;
        best_idx <= cand_idx;
        scan_ptr <= scan_ptr + 1'b1;
      end

      if (scan_end) begin
        class_idx   <= cand_idx;
        class_max   <= cand_val;
        class_valid <= 1'b1;
        out_ptr     <= '0;
        out_valid   <= 1'b1;
        out_data    <= lat[0];
        out_last    <= 1'b0;
      end

      // the byte after the last element carries the class index
      if (xfer) begin
        out_ptr <= out_nxt;
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else if (out_nxt == PTR_W'(OUT_N)) begin
          out_data <= DATA_WIDTH'(class_idx);
          out_last <= 1'b1;
        end else begin
          out_data <= lat[out_nxt];
        end
      end
    end
  end

endmodule

// File: doc/result_output_unit.md
Name: result_output_unit

Overview:
- Downstream of the accelerator top level; consumes the final signed result vector y[0:OUT_N-1] when the top level pulses done.
- Latches the vector and computes the argmax (predicted class) with a sequential one-element-per-cycle scan.
- Streams the latched results, then the class index, to the host over a valid/ready byte stream.
- Holds the class index and its score stable for status readout until the next capture.

Parameters:
- DATA_WIDTH, 8, width of one signed result element and of the stream byte.
- OUT_N, 10, number of result elements (classes); must be 2..256.
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= OUT_N and IDX_WIDTH <= DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- capture  in  1  single-cycle pulse; connected to the top-level done.
- y_in  in  OUT_N x DATA_WIDTH signed  result vector; sampled only on an accepted capture.
- busy  out  1  high in SCAN or STREAM.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  host ready.
- out_data  out  DATA_WIDTH  stream byte.
- out_last  out  1  marks the final byte of a frame.
- class_idx  out  IDX_WIDTH  argmax index.
- class_max  out  DATA_WIDTH signed  value at class_idx.
- class_valid  out  1  class_idx and class_max are valid.

Behaviour:
- Reset clears all state and outputs: state=IDLE; busy, out_valid, out_last, class_valid = 0; out_data, class_idx, class_max = 0; latched vector = 0.
- Reset asserted mid-SCAN or mid-STREAM aborts the frame immediately; no partial frame resumes.
- States: IDLE, SCAN, STREAM, HOLD.
- Capture is accepted in IDLE or HOLD.
  - On the accepting edge: latch all y_in, best_val<=y_in[0], best_idx<=0, scan_ptr<=1, class_valid<=0, state<=SCAN.
  - Capture in SCAN or STREAM is ignored; the frame in flight is unaffected.
- SCAN, one edge per element:
  - If lat[scan_ptr] > best_val (signed, strict), best_val<=lat[scan_ptr] and best_idx<=scan_ptr.
  - scan_ptr increments each edge.
  - On the edge that processes scan_ptr==OUT_N-1: class_idx<=final best_idx, class_max<=final best_val, class_valid<=1, out_ptr<=0, state<=STREAM, out_valid<=1.
  - Ties resolve to the lowest index.
  - out_valid and class_valid rise OUT_N-1 edges after the capture edge (9 for OUT_N=10).
- STREAM: frame is OUT_N+1 bytes.
  - Bytes 0..OUT_N-1: out_data = lat[out_ptr] (two's-complement bits).
  - Byte OUT_N: out_data = class_idx zero-extended, with out_last=1.
  - Transfer occurs on an edge with out_valid && out_ready; out_ptr then advances.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid stays high between beats, with no bubbles, while ready is high.
  - After the last transfer: out_valid<=0, out_last<=0, state<=HOLD.
- HOLD: class_valid=1, class_idx and class_max stable, busy=0. A capture starts a new frame.
- busy=1 from the capture edge until the edge completing the last transfer.
- Minimum frame time with out_ready constantly high: capture to the last transfer = (OUT_N-1) + (OUT_N+1) edges.

Test Plan:
- Reset then capture y={3,-5,12,7,0,1,2,12,-128,127}.
  - class_idx=9, class_max=127; class_valid rises 9 edges after capture.
  - Stream is 03,FB,0C,07,00,01,02,0C,80,7F,09 with out_last only on 09; 11 consecutive beats with out_ready=1.
- Ties: y={5,5,5,5,5,5,5,5,5,5}.
  - class_idx=0, class_max=5.
  - All negative, y={-1,-2,...,-10} (y[k]=-(k+1)): class_idx=0, class_max=-1.
- Backpressure: toggle out_ready 1,0,0,1,... during STREAM.
  - out_data and out_last stay stable across stalls; exactly 11 beats transfer; values match the first test.
- Capture pulse during SCAN and again during STREAM with a different y_in.
  - Both are ignored; the frame equals the original vector.
  - A capture in HOLD starts a new frame with the new argmax and drops class_valid on the capture edge.
- Assert rst at the 4th stream beat.
  - All outputs return to reset values on the same edge.
  - A subsequent capture produces a complete fresh 11-byte frame.
